sram_bank_responder: RTL
========================

// Module: sram_bank_responder
// PURPOSE
//  Responder side of the memory-controller SRAM interface: a bank of Nums_SRAM independent
//  single-clock SRAMs driven by per-SRAM chip-select, read/write enables and packed
//  read/write addresses. Serves load, compute and write-back traffic for the dot-product
//  datapath with 1-cycle registered reads, per-SRAM hardware clear and collision reporting.
// PARAMETERS
//  Addr_Width  4                    address bits per SRAM
//  Ram_Depth   1 << Addr_Width      words per SRAM (<= 2**Addr_Width)
//  Nums_SRAM   3                    SRAMs in bank (2 input + 1 output in default system)
//  Data_Width  16                   bits per word
// PORTS
//  clk             in   1                       rising-edge clock
//  Mem_reset       in   1                       sync, active-high reset
//  Mem_Clear       in   Nums_SRAM               per-SRAM clear request (level)
//  En_Chip_Select  in   Nums_SRAM               per-SRAM select; gates all access
//  En_Write        in   Nums_SRAM               per-SRAM write enable
//  En_Read         in   Nums_SRAM               per-SRAM read enable
//  Addr_Write      in   Nums_SRAM*Addr_Width    packed; SRAM i at [i*Addr_Width +: Addr_Width]
//  Addr_Read       in   Nums_SRAM*Addr_Width    packed, same slicing
//  Data_In         in   Nums_SRAM*Data_Width    packed write data
//  Data_Out        out  Nums_SRAM*Data_Width    packed registered read data
//  Data_Valid      out  Nums_SRAM               Data_Out slice valid this cycle
//  Clear_Busy      out  Nums_SRAM               SRAM i clear sequence running
//  Collision       out  Nums_SRAM               same-address read+write seen last cycle
// BEHAVIOUR
//  - Reset: Data_Out=0, Data_Valid=0, Clear_Busy=0, Collision=0, all clear FSMs IDLE.
//    Array contents are not reset.
//  - Write: cycle t with CS[i]&En_Write[i]&(Addr_Write<Ram_Depth) -> word stored at edge t.
//    Addr_Write>=Ram_Depth: write dropped silently.
//  - Read: cycle t with CS[i]&En_Read[i] -> Data_Out slice + Data_Valid[i]=1 in cycle t+1.
//    Addr_Read>=Ram_Depth returns 0 (still valid). No read -> Data_Valid[i]=0, Data_Out holds.
//  - Same-address read+write same cycle: read-first (old word returned); Collision[i]=1 at t+1.
//  - CS[i]=0: En_Read/En_Write ignored, no Collision.
//  - Clear FSM per SRAM: IDLE -> CLEAR when Mem_Clear[i]=1. CLEAR writes 0 to address
//    clr_cnt (0..Ram_Depth-1), one per cycle; Clear_Busy[i]=1 throughout; exactly Ram_Depth
//    cycles. Last address -> HOLD. HOLD -> IDLE when Mem_Clear[i]=0 (no retrigger while held).
//  - During CLEAR: external writes dropped; reads served normally (may return 0 or old word
//    by clear progress); Collision not raised by clear writes.
//  - Mem_reset mid-clear: FSM to IDLE at once; array left partially cleared.
//  - Counter clr_cnt is Addr_Width+1 bits; no wrap-around with Ram_Depth = 2**Addr_Width.
//  - SRAMs fully independent; simultaneous activity on all SRAMs legal.
// CONFIGURATION
//  WRITE_FIRST_BYPASS_EN defined: same-address read+write forwards Data_In (new word) to
//    Data_Out at t+1; Collision still asserted.
//  Not defined: read-first, as above.
// TESTING
//  1 Reset, write 0xA5A5 to SRAM0 addr 3, read addr 3 next cycle -> Data_Out[15:0]=0xA5A5,
//    Data_Valid[0]=1 exactly one cycle later.
//  2 SRAM2 holds 0x1111 @5; same cycle write 0x2222 @5 + read @5 -> 0x1111 (0x2222 with
//    WRITE_FIRST_BYPASS_EN), Collision[2]=1 one cycle, then read @5 -> 0x2222.
//  3 Fill SRAM1 with 1..16, pulse Mem_Clear[1] 20 cycles -> Clear_Busy[1]=1 16 cycles,
//    all 16 reads return 0; SRAM0/SRAM2 unchanged.
//  4 Mem_reset at clear cycle 8 -> Clear_Busy=0 next cycle; addrs 0..7 read 0, 8..15 intact.
//  5 CS[0]=0 with En_Write/En_Read=1 -> no array change, Data_Valid[0]=0, Collision[0]=0.
//  6 Ram_Depth=12: write 0xFFFF @13 then read @13 -> 0 valid; addrs 0..11 unchanged.

Source files
------------

// File: rtl/sram_bank_responder_if.sv
// Bundled request/response signals between the memory controller (master) and
// the SRAM bank responder (slave).
interface sram_bank_responder_if #(
    parameter int Addr_Width = 4,
    parameter int Nums_SRAM  = 3,
    parameter int Data_Width = 16
);
    logic [Nums_SRAM-1:0]            Mem_Clear;
    logic [Nums_SRAM-1:0]            En_Chip_Select;
    logic [Nums_SRAM-1:0]            En_Write;
    logic [Nums_SRAM-1:0]            En_Read;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Write;
    logic [Nums_SRAM*Addr_Width-1:0] Addr_Read;
    logic [Nums_SRAM*Data_Width-1:0] Data_In;
    logic [Nums_SRAM*Data_Width-1:0] Data_Out;
    logic [Nums_SRAM-1:0]            Data_Valid;
    logic [Nums_SRAM-1:0]            Clear_Busy;
    logic [Nums_SRAM-1:0]            Collision;

    modport master (
        output Mem_Clear, En_Chip_Select, En_Write, En_Read,
        output Addr_Write, Addr_Read, Data_In,
        input  Data_Out, Data_Valid, Clear_Busy, Collision
    );

    modport slave (
        input  Mem_Clear, En_Chip_Select, En_Write, En_Read,
        input  Addr_Write, Addr_Read, Data_In,
        output Data_Out, Data_Valid, Clear_Busy, Collision
    );
endinterface

// File: rtl/sram_bank_responder.sv
// Bank of independent single-clock SRAMs with registered reads, per-SRAM hardware clear
// and collision flags. Define WRITE_FIRST_BYPASS_EN to forward same-address write data.
module sram_bank_responder #(
    parameter int Addr_Width = 4,
    parameter int Ram_Depth  = 1 << Addr_Width,
    parameter int Nums_SRAM  = 3,
    parameter int Data_Width = 16
) (
    input logic                  clk,
    input logic                  Mem_reset,
    sram_bank_responder_if.slave bus
);
    localparam logic [Addr_Width:0] DEPTH = (Addr_Width + 1)'(Ram_Depth);
    localparam logic [Addr_Width:0] LAST  = (Addr_Width + 1)'(Ram_Depth - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        HOLD
    } clr_state_t;

    for (genvar i = 0; i < Nums_SRAM; i++) begin : g_sram
        logic [Data_Width-1:0] mem [Ram_Depth];
        logic [Addr_Width-1:0] wa;
        logic [Addr_Width-1:0] ra;
        logic [Data_Width-1:0] wdata;
        logic [Data_Width-1:0] rdata;
        logic                  wa_in;
        logic                  ra_in;
        logic                  wr_ok;
        logic                  rd_ok;
        logic                  same;

        clr_state_t            state;
        logic [Addr_Width:0]   clr_cnt;
        logic                  busy;
        logic                  valid;
        logic                  coll;
        logic [Data_Width-1:0] dout;

        assign wa    = bus.Addr_Write[i*Addr_Width +: Addr_Width];
        assign ra    = bus.Addr_Read[i*Addr_Width +: Addr_Width];
        assign wdata = bus.Data_In[i*Data_Width +: Data_Width];
        assign wa_in = {1'b0, wa} < DEPTH;
        assign ra_in = {1'b0, ra} < DEPTH;
        // External writes are locked out while the clear sequence owns the write port.
        assign wr_ok = bus.En_Chip_Select[i] & bus.En_Write[i] & (state != CLEAR);
        assign rd_ok = bus.En_Chip_Select[i] & bus.En_Read[i];
        assign same  = wr_ok & rd_ok & (wa == ra);

        always_comb begin
            rdata = ra_in ? mem[ra] : '0;
`ifdef WRITE_FIRST_BYPASS_EN
            if (same && ra_in) rdata = wdata;
`endif
        end

        always_ff @(posedge clk) begin
            if (state == CLEAR && !Mem_reset) begin
                mem[clr_cnt[Addr_Width-1:0]] <= '0;
            end else if (wr_ok && wa_in) begin
                mem[wa] <= wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (Mem_reset) begin
                state   <= IDLE;
                clr_cnt <= '0;
                busy    <= 1'b0;
                valid   <= 1'b0;
                coll    <= 1'b0;
                dout    <= '0;
            end else begin
                valid <= rd_ok;
                coll  <= same;
                if (rd_ok) dout <= rdata;
                case (state)
                    IDLE: begin
                        if (bus.Mem_Clear[i]) begin
                            state   <= CLEAR;
                            clr_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        if (clr_cnt == LAST) begin
                            state   <= HOLD;
                            clr_cnt <= '0;
                            busy    <= 1'b0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        // Request must drop before another clear can start.
                        if (!bus.Mem_Clear[i]) state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.Data_Out[i*Data_Width +: Data_Width] = dout;
        assign bus.Data_Valid[i] = valid;
        assign bus.Clear_Busy[i] = busy;
        assign bus.Collision[i]  = coll;
    end
endmodule
